clock_set_controller: RTL

Front-end sequencer for the digital-clock mini project. Conditions the raw active-low switch, add and deduct pushbuttons, and runs the RUN/SET_SEC/SET_MIN/SET_HOUR mode state machine. Produces the gated 1 Hz tick and single-cycle increment/decrement strobes for the second, minute and hour counters. Sits between the board buttons and the three counter modules and replaces the free-running switch-count logic.

---
 rtl/clock_set_controller_if.sv | 24 ++
 rtl/clock_set_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller_if.sv
// Button/strobe bundle between the board pushbuttons, the mode sequencer
// and the second/minute/hour counters.
interface clock_set_controller_if;
    logic       switch_n;
    logic       add_n;
    logic       deduct_n;
    logic       tick_1hz;
    logic       mode;
    logic [1:0] field_sel;
    logic [2:0] inc;
    logic [2:0] dec;

    // Board / test side: drives the raw buttons, observes the strobes
    modport master (
        output switch_n, add_n, deduct_n,
        input  tick_1hz, mode, field_sel, inc, dec
    );

    // Sequencer side
    modport slave (
        input  switch_n, add_n, deduct_n,
        output tick_1hz, mode, field_sel, inc, dec
    );
endinterface

// File: rtl/clock_set_controller.sv
// Digital-clock front end: button conditioning, RUN/SET_SEC/SET_MIN/SET_HOUR
// mode sequencer, gated 1 Hz tick and inc/dec strobes for the counters.
// Optional macro AUTO_REPEAT_EN: held add/deduct buttons auto-repeat.

// One button: 2-flop synchronizer, stability-count debouncer, press event.
module clock_set_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;

    // Two-stage synchronizer, released (1) out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES stable cycles;
    // the press (1->0) event is registered alongside the flip.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    fall  <= level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module clock_set_controller #(
    parameter int CLK_FREQ        = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_SEC     = 10,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 6250000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clock_set_controller_if.slave bus
);
    localparam int PW = $clog2(CLK_FREQ);
    localparam int IW = (TIMEOUT_SEC > 0) ? $clog2(TIMEOUT_SEC + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_SEC);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_SEC  = 2'b01,
        SET_MIN  = 2'b10,
        SET_HOUR = 2'b11
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] presc;
    logic [IW-1:0] idle;
    logic          wrap;
    logic          timeout_hit;
    logic          keep_state;
    logic          in_set;

    logic [2:0]    raw_n;
    logic [2:0]    btn_lvl;
    logic [2:0]    btn_fall;
    logic          sw_ev;
    logic          add_ev;
    logic          ded_ev;
    logic          rpt;
    logic          rpt_up;
    logic          rpt_dn;
    logic          unused_cfg;

    logic [2:0]    field_mask;
    logic [2:0]    inc_next;
    logic [2:0]    dec_next;
    logic          mode_q;
    logic [1:0]    field_q;
    logic [2:0]    inc_q;
    logic [2:0]    dec_q;

    // Bit 0 switch, bit 1 add, bit 2 deduct
    assign raw_n = {bus.deduct_n, bus.add_n, bus.switch_n};

    generate
        for (genvar b = 0; b < 3; b++) begin : g_btn
            clock_set_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_n[b]),
                .level (btn_lvl[b]),
                .fall  (btn_fall[b])
            );
        end
    endgenerate

    assign sw_ev  = btn_fall[0];
    assign add_ev = btn_fall[1];
    assign ded_ev = btn_fall[2];

    assign in_set      = (state != RUN);
    assign wrap        = (presc == PRESC_LAST);
    assign timeout_hit = in_set && (TIMEOUT_SEC != 0) && (idle == IDLE_LIMIT);
    // Any state change this cycle drops add/deduct activity
    assign keep_state  = !timeout_hit && !sw_ev;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(RMAX + 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] rpt_target;
    logic          hold_rep;
    logic          hold_ok;

    // Repeats need exactly one of add/deduct held in a steady SET state
    assign hold_ok    = in_set && keep_state && (btn_lvl[1] ^ btn_lvl[2]);
    assign rpt_target = hold_rep ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY);
    assign rpt        = hold_ok && (hold_cnt != '0) && (hold_cnt == rpt_target);
    assign rpt_up     = rpt && !btn_lvl[1];
    assign rpt_dn     = rpt && !btn_lvl[2];
    // Switch level only matters for its press event
    assign unused_cfg = btn_lvl[0];

    // Hold timer: starts at the press event, first repeat after
    // REPEAT_DELAY, then every REPEAT_PERIOD; zero means idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !hold_ok) begin
            hold_cnt <= '0;
            hold_rep <= 1'b0;
        end else if (add_ev || ded_ev) begin
            hold_cnt <= HW'(1);
            hold_rep <= 1'b0;
        end else if (rpt) begin
            hold_cnt <= HW'(1);
            hold_rep <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign rpt    = 1'b0;
    assign rpt_up = 1'b0;
    assign rpt_dn = 1'b0;
    // Button levels and repeat timing only feed the auto-repeat logic
    assign unused_cfg = ^{btn_lvl, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // Mode state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and next strobes; timeout wins over a switch press
    always_comb begin
        next_state = state;
        field_mask = 3'b000;
        inc_next   = 3'b000;
        dec_next   = 3'b000;

        case (state)
            SET_SEC:  field_mask = 3'b001;
            SET_MIN:  field_mask = 3'b010;
            SET_HOUR: field_mask = 3'b100;
            default:  field_mask = 3'b000;
        endcase

        if (timeout_hit) begin
            next_state = RUN;
        end else if (sw_ev) begin
            case (state)
                RUN:      next_state = SET_SEC;
                SET_SEC:  next_state = SET_MIN;
                SET_MIN:  next_state = SET_HOUR;
                default:  next_state = RUN;
            endcase
        end

        // Simultaneous add and deduct cancel each other
        if (in_set && keep_state) begin
            if ((add_ev || rpt_up) && !(ded_ev || rpt_dn)) begin
                inc_next = field_mask;
            end else if ((ded_ev || rpt_dn) && !(add_ev || rpt_up)) begin
                dec_next = field_mask;
            end
        end
    end

    // Registered mode/field/strobe outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            field_q <= 2'b00;
            inc_q   <= 3'b000;
            dec_q   <= 3'b000;
        end else begin
            mode_q  <= (next_state != RUN);
            field_q <= next_state;
            inc_q   <= inc_next;
            dec_q   <= dec_next;
        end
    end

    // Free-running prescaler, realigned on every entry into RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if ((in_set && next_state == RUN) || wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Idle seconds in a SET state; any button activity restarts it
    always_ff @(posedge clk) begin
        if (!rst_n || !in_set || next_state != state) begin
            idle <= '0;
        end else if (sw_ev || add_ev || ded_ev || rpt) begin
            idle <= '0;
        end else if (wrap && TIMEOUT_SEC != 0) begin
            idle <= idle + 1'b1;
        end
    end

    assign bus.tick_1hz  = wrap && (state == RUN);
    assign bus.mode      = mode_q;
    assign bus.field_sel = field_q;
    assign bus.inc       = inc_q;
    assign bus.dec       = dec_q;
endmodule
